image_box_blur: RTL and testbench

IMAGE_BOX_BLUR -- requirements
Module: image_box_blur

---
 rtl/image_box_blur_pkg.sv | 14 +
 rtl/image_box_blur_line_buffer.sv | 16 +
 rtl/image_box_blur.sv | 123 ++++++++++++
 tb/tb_image_box_blur.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/image_box_blur_pkg.sv
// image_box_blur_pkg: shared state encoding, widths, pixel type and divide-by-9 helper
package image_box_blur_pkg;
   localparam int PIX_W = 8;
   localparam int SUM_W = 12;
   typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
   typedef struct packed {
      logic [PIX_W-1:0] r;
      logic [PIX_W-1:0] g;
      logic [PIX_W-1:0] b;
   } rgb_t;
   function automatic logic [PIX_W-1:0] div9(input logic [SUM_W-1:0] sum);
      return PIX_W'(sum / SUM_W'(9));
   endfunction
endpackage

// File: rtl/image_box_blur_line_buffer.sv
// image_box_blur_line_buffer: one image row of RGB pixels, read-before-write at the same column
module image_box_blur_line_buffer import image_box_blur_pkg::*; #(
   parameter int DEPTH = 768
) (
   input  logic                     HCLK,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  rgb_t                     wdata,
   output rgb_t                     rdata
);
   rgb_t mem [DEPTH];
   // store the incoming pixel over the one from a row earlier at this column
   always_ff @(posedge HCLK)
      if (wr_en) mem[addr] <= wdata;
   assign rdata = mem[addr];
endmodule

// File: rtl/image_box_blur.sv
// image_box_blur: streaming 3x3 box blur with border pass-through
module image_box_blur import image_box_blur_pkg::*; #(
   parameter int WIDTH  = 768,
   parameter int HEIGHT = 512
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] DATA_R,
   input  logic [PIX_W-1:0] DATA_G,
   input  logic [PIX_W-1:0] DATA_B,
   output logic             out_valid,
   output logic [PIX_W-1:0] OUT_R,
   output logic [PIX_W-1:0] OUT_G,
   output logic [PIX_W-1:0] OUT_B,
   output logic             frame_done
);
   localparam int CW = $clog2(WIDTH);
   localparam int RW = $clog2(HEIGHT);
   state_t           state, state_nx;
   logic [CW-1:0]    in_col, out_col;
   logic [RW-1:0]    in_row, out_row;
   logic             adv, emit, in_last, out_last, interior;
   logic [SUM_W-1:0] sum;
   rgb_t             pix, lb1_q, lb2_q, res;
   rgb_t             col [3];
   rgb_t             win_a [3];
   rgb_t             win_b [3];

   // FLUSH keeps the pipeline moving without input to drain the last row
   assign adv      = (in_valid && in_ready) || state == FLUSH;
   assign in_last  = in_row == RW'(HEIGHT-1) && in_col == CW'(WIDTH-1);
   assign out_last = out_row == RW'(HEIGHT-1) && out_col == CW'(WIDTH-1);
   assign interior = out_row != '0 && out_row != RW'(HEIGHT-1) && out_col != '0 && out_col != CW'(WIDTH-1);
   assign pix      = {DATA_R, DATA_G, DATA_B};
   assign col      = '{lb2_q, lb1_q, pix};

   image_box_blur_line_buffer #(.DEPTH(WIDTH)) u_lb1 (
      .HCLK(HCLK), .wr_en(adv), .addr(in_col), .wdata(pix), .rdata(lb1_q));
   image_box_blur_line_buffer #(.DEPTH(WIDTH)) u_lb2 (
      .HCLK(HCLK), .wr_en(adv), .addr(in_col), .wdata(lb1_q), .rdata(lb2_q));

   // next state and output strobe; output k leaves on the edge that takes input k+WIDTH+1
   always_comb begin
      state_nx = state;
      emit     = 1'b0;
      case (state)
         IDLE:  state_nx = adv ? FILL : IDLE;
         FILL:  begin
            emit     = adv && in_row == RW'(1) && in_col == CW'(1);
            state_nx = emit ? RUN : FILL;
         end
         RUN:   begin
            emit     = adv;
            state_nx = adv && in_last ? FLUSH : RUN;
         end
         FLUSH: begin
            emit     = 1'b1;
            state_nx = out_last ? IDLE : FLUSH;
         end
      endcase
   end

   // state, ready flag and raster position counters for input and output
   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) begin
         state    <= IDLE;
         in_ready <= 1'b0;
         in_col   <= '0;
         in_row   <= '0;
         out_col  <= '0;
         out_row  <= '0;
      end else begin
         state    <= state_nx;
         in_ready <= state_nx != FLUSH;
         if (state == FLUSH && state_nx == IDLE) begin
            in_col <= '0;
            in_row <= '0;
         end else if (adv) begin
            in_col <= in_col == CW'(WIDTH-1) ? '0 : in_col + 1'b1;
            if (in_col == CW'(WIDTH-1)) in_row <= in_row == RW'(HEIGHT-1) ? '0 : in_row + 1'b1;
         end
         if (emit) begin
            out_col <= out_col == CW'(WIDTH-1) ? '0 : out_col + 1'b1;
            if (out_col == CW'(WIDTH-1)) out_row <= out_row == RW'(HEIGHT-1) ? '0 : out_row + 1'b1;
         end
      end

   // two most recent columns of three rows; the live column completes the 3x3 window
   always_ff @(posedge HCLK)
      if (adv) begin
         win_a <= win_b;
         win_b <= col;
      end

   // centre pixel is always the middle row of the newest stored column
   always_comb begin
      res = win_b[1];
      sum = '0;
      for (int i = 0; i < 3; i++) begin
         sum = '0;
         for (int j = 0; j < 3; j++)
            sum = sum + SUM_W'(win_a[j][PIX_W*i +: PIX_W]) + SUM_W'(win_b[j][PIX_W*i +: PIX_W])
                      + SUM_W'(col[j][PIX_W*i +: PIX_W]);
         if (interior) res[PIX_W*i +: PIX_W] = div9(sum);
      end
   end

   // registered outputs hold their value between valid cycles
   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) begin
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
         OUT_R      <= '0;
         OUT_G      <= '0;
         OUT_B      <= '0;
      end else begin
         out_valid  <= emit;
         frame_done <= emit && out_last;
         if (emit) {OUT_R, OUT_G, OUT_B} <= res;
      end
endmodule

// File: tb/tb_image_box_blur.sv
// tb_image_box_blur: random and directed frames checked against a 3x3 box blur reference
module tb_image_box_blur;
   localparam int W = 4, H = 4, N = W*H;
   typedef struct packed {logic [23:0] pix; logic last;} exp_t;
   logic HCLK = 0, HRESETn = 1, in_valid = 0, in_ready, out_valid, frame_done;
   logic [7:0] DATA_R = 0, DATA_G = 0, DATA_B = 0, OUT_R, OUT_G, OUT_B;
   exp_t exp_q [$];
   exp_t e_m;
   logic [23:0] last_out = 0;
   logic [23:0] got [N];
   logic [7:0] fr [3][N];
   int oidx = 0, n_cmp = 0, n_bad = 0, n_done = 0, nf = 0;

   image_box_blur #(.WIDTH(W), .HEIGHT(H)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .in_valid(in_valid), .in_ready(in_ready),
      .DATA_R(DATA_R), .DATA_G(DATA_G), .DATA_B(DATA_B), .out_valid(out_valid),
      .OUT_R(OUT_R), .OUT_G(OUT_G), .OUT_B(OUT_B), .frame_done(frame_done));

   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
      n_cmp++;
      if (got_v !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
      end
   endtask

   function automatic logic [7:0] blur(input int k, input int r, input int c);
      int s = 0;
      if (r == 0 || r == H-1 || c == 0 || c == W-1) return fr[k][r*W+c];
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++) s += fr[k][(r+dr)*W+c+dc];
      return 8'(s / 9);
   endfunction

   task automatic make_frame(input int mode);
      for (int p = 0; p < N; p++)
         for (int k = 0; k < 3; k++)
            fr[k][p] = mode == 0 ? 8'd90 : mode == 1 ? (k == 0 ? 8'(p) : 8'd0) : mode == 2 ? 8'd255 :
                       mode == 3 ? 8'd8 : mode == 4 ? ((k == 1 && p == W+1) ? 8'd255 : 8'd0) :
                       8'($urandom_range(0, 255));
      for (int p = 0; p < N; p++)
         exp_q.push_back('{{blur(0, p/W, p%W), blur(1, p/W, p%W), blur(2, p/W, p%W)}, p == N-1});
   endtask

   task automatic send_frame(input int mode, input bit gaps, input int n_send);
      make_frame(mode);
      for (int p = 0; p < n_send; p++) begin
         if (gaps && p > 0)
            repeat ($urandom_range(0, 2)) begin
               in_valid = 0;
               @(negedge HCLK);
               check("gap_out_valid", out_valid, 0);
            end
         in_valid = 1;
         DATA_R = fr[0][p]; DATA_G = fr[1][p]; DATA_B = fr[2][p];
         for (int t = 0; !in_ready && t < 50; t++) @(negedge HCLK);
         check("ready_before_xfer", in_ready, 1);
         @(negedge HCLK);
         check("xfer_out_valid", out_valid, p >= W+1);
         check("xfer_in_ready", in_ready, p != N-1);
      end
      in_valid = 0;
      if (n_send < N) return;
      for (int i = 1; i <= W+1; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         DATA_R = 8'($urandom);
         @(negedge HCLK);
         check("flush_out_valid", out_valid, 1);
         check("flush_in_ready", in_ready, i == W+1);
         check("flush_frame_done", frame_done, i == W+1);
      end
      in_valid = 0;
   endtask

   always @(negedge HCLK) begin
      if (!HRESETn) begin
         last_out = 0;
         oidx = 0;
      end else if (out_valid) begin
         if (exp_q.size() == 0) check("unexpected_output", out_valid, 0);
         else begin
            e_m = exp_q.pop_front();
            check("pixel", {OUT_R, OUT_G, OUT_B}, e_m.pix);
            check("frame_done", frame_done, e_m.last);
            got[oidx] = {OUT_R, OUT_G, OUT_B};
            oidx = e_m.last ? 0 : oidx + 1;
            n_done += int'(frame_done);
         end
         last_out = {OUT_R, OUT_G, OUT_B};
      end else begin
         check("hold_out", {OUT_R, OUT_G, OUT_B}, last_out);
         check("idle_frame_done", frame_done, 0);
      end
   end

   initial begin
      #1 HRESETn = 0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_out", {OUT_R, OUT_G, OUT_B}, 0);
      check("rst_in_ready", in_ready, 0);
      repeat (2) @(negedge HCLK);
      #2 HRESETn = 1;
      @(negedge HCLK);
      check("ready_after_reset", in_ready, 1);
      send_frame(0, 0, N); nf++;
      @(negedge HCLK);
      check("flat90", got[6], 24'h5a5a5a);
      send_frame(1, 0, N); nf++;
      @(negedge HCLK);
      check("ramp_r_1_1", got[5][23:16], 5);
      check("ramp_r_1_2", got[6][23:16], 6);
      check("ramp_border", got[7][23:16], 7);
      send_frame(2, 0, N); nf++;
      @(negedge HCLK);
      check("all255", got[5], 24'hffffff);
      send_frame(3, 0, N); nf++;
      @(negedge HCLK);
      check("all8", got[10], 24'h080808);
      send_frame(4, 0, N); nf++;
      @(negedge HCLK);
      check("single255_1_1", got[5][15:8], 28);
      check("single255_2_2", got[10][15:8], 28);
      repeat (2) begin send_frame(5, 0, N); nf++; end
      repeat (4) begin send_frame(5, 1, N); nf++; end
      send_frame(5, 0, 10);
      #2 HRESETn = 0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out", {OUT_R, OUT_G, OUT_B}, 0);
      check("midrst_in_ready", in_ready, 0);
      exp_q.delete();
      @(negedge HCLK);
      #2 HRESETn = 1;
      @(negedge HCLK);
      check("ready_after_midrst", in_ready, 1);
      send_frame(5, 1, N); nf++;
      repeat (3) @(negedge HCLK);
      check("queue_empty", exp_q.size(), 0);
      check("frame_done_count", n_done, nf);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
